// File: rtl/mux_nto1_rr.sv
// Registered N-to-1 stream multiplexer with valid/ready handshakes.
// Channel choice is either a fixed select or round-robin over valid channels.
module mux_nto1_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic             fix_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             ld;
  logic [WIDTH-1:0] grant_data;
  int               idx;
  logic [SEL_W-1:0] idx_sel;

  // Search upward from the channel after the last round-robin grant, wrapping.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    idx      = 0;
    idx_sel  = '0;
    for (int k = 1; k <= N; k++) begin
      idx     = (int'(ptr) + k) % N;
      idx_sel = SEL_W'(idx);
      if (!rr_found && in_valid[idx_sel]) begin
        rr_found = 1'b1;
        rr_grant = idx_sel;
      end
    end
  end

  always_comb begin
    fix_valid = 1'b0;
    if (int'(sel) < N) fix_valid = in_valid[sel];
  end

  assign grant       = mode ? rr_grant : sel;
  assign grant_valid = mode ? rr_found : fix_valid;
  assign ld          = rst_n && (!out_valid || out_ready) && grant_valid;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = ld && (grant == SEL_W'(i));
      if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Pointer starts at N-1 so channel 0 wins the first round-robin search.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SEL_W'(N - 1);
    end else if (ld) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant;
      if (mode) ptr <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
